// File: rtl/game_pkg.sv
// Shared game definitions: scene encodings, screen limits, enemy slot record,
// scheduler state encoding and spawn timing constants.
package game_pkg;

    localparam int N_SLOTS       = 4;
    localparam int SLOT_W        = 2;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int BASE_INTERVAL = 60;
    localparam int INTERVAL_STEP = 3;
    localparam int MIN_INTERVAL  = 12;

    localparam logic [1:0] SCENE_START = 2'd0;
    localparam logic [1:0] SCENE_PLAY  = 2'd1;
    localparam logic [1:0] SCENE_LOST  = 2'd2;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
    } enemy_t;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_MOVE  = 2'd2,
        ST_SPAWN = 2'd3
    } sched_state_t;

    // Enemies fall faster every four levels: 1 px/tick at level 1..3, up to 8.
    function automatic logic [3:0] enemy_speed(input logic [4:0] level);
        return 4'd1 + {1'b0, level[4:2]};
    endfunction

endpackage

// File: rtl/spawn_interval.sv
// Level-dependent spawn interval with a reloadable down-counter. One step per
// frame pass; expire flags the pass on which the counter runs out and reloads.
module spawn_interval
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] level,
    input  logic       clear,
    input  logic       step,
    output logic       expire
);

    logic [7:0] count_q;
    logic [7:0] level_m1;
    logic [7:0] reduction;
    logic [7:0] raw;
    logic [7:0] interval;

    always_comb begin
        level_m1  = (level == 5'd0) ? 8'd0 : {3'd0, level} - 8'd1;
        reduction = 8'(INTERVAL_STEP) * level_m1;
        raw       = 8'(BASE_INTERVAL) - reduction;
        // A reduction larger than the base would wrap, so it clamps like a short interval.
        if (reduction > 8'(BASE_INTERVAL) || raw < 8'(MIN_INTERVAL)) begin
            interval = 8'(MIN_INTERVAL);
        end else begin
            interval = raw;
        end
    end

    // A counter of 0 (fresh game) counts as already expired.
    assign expire = step && (count_q <= 8'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= 8'd0;
        end else if (expire) begin
            count_q <= interval;
        end else if (step) begin
            count_q <= count_q - 8'd1;
        end
    end

endmodule

// File: rtl/enemy_scheduler.sv
// Enemy slot table: spawns enemies at a level-dependent interval, moves one slot
// per cycle after each frame tick, and reports enemies leaving the bottom edge.
module enemy_scheduler
    import game_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              scene,
    input  logic [4:0]              level,
    input  logic                    tick,
    input  logic [7:0]              rand_val,
    input  logic                    kill_valid,
    input  logic [SLOT_W-1:0]       kill_slot,
    output logic                    spawned,
    output logic                    avoided,
    output logic [N_SLOTS-1:0]      enemy_active,
    output logic [10*N_SLOTS-1:0]   enemy_x,
    output logic [10*N_SLOTS-1:0]   enemy_y,
    output logic [1:0]              dbg_state
);

    // Handshake: tick and kill_valid are single-cycle strobes with no ready;
    // avoided is a single-cycle strobe, one per enemy crossing SCREEN_H.

    sched_state_t        state_q, state_d;
    logic [SLOT_W-1:0]   idx_q, idx_d;
    logic [1:0]          scene_q;
    enemy_t              slot_q [N_SLOTS];
    enemy_t              slot_d [N_SLOTS];
    logic                avoided_d;
    logic                spawned_d;

    logic                cnt_clear;
    logic                cnt_step;
    logic                cnt_expire;
    logic                do_spawn;
    logic [SLOT_W-1:0]   spawn_idx;
    logic                any_active;
    logic                any_active_d;
    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;
    logic [3:0]          speed;
    logic [10:0]         move_y;

    spawn_interval u_interval (
        .clk    (clk),
        .rst    (rst),
        .level  (level),
        .clear  (cnt_clear),
        .step   (cnt_step),
        .expire (cnt_expire)
    );

    assign speed     = enemy_speed(level);
    assign dbg_state = state_q;

    always_comb begin
        any_active = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            any_active = any_active | slot_q[i].active;
            if (!slot_q[i].active) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        slot_d    = slot_q;
        state_d   = state_q;
        idx_d     = idx_q;
        avoided_d = 1'b0;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        do_spawn  = 1'b0;
        spawn_idx = '0;
        move_y    = {1'b0, slot_q[idx_q].y} + {7'd0, speed};

        case (state_q)
            ST_ARM: begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    slot_d[i] = '0;
                end
                cnt_clear = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end
            ST_MOVE: begin
                if (scene == SCENE_PLAY && slot_q[idx_q].active) begin
                    if (move_y >= 11'(SCREEN_H)) begin
                        slot_d[idx_q].active = 1'b0;
                        avoided_d            = 1'b1;
                    end else begin
                        slot_d[idx_q].y = move_y[9:0];
                    end
                end
                if (idx_q == SLOT_W'(N_SLOTS - 1)) begin
                    state_d = ST_SPAWN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SPAWN: begin
                state_d = ST_WAIT;
                if (scene == SCENE_START && !any_active) begin
                    do_spawn  = 1'b1;
                    spawn_idx = '0;
                end else if (scene == SCENE_PLAY) begin
                    cnt_step = 1'b1;
                    // A full table on expiry drops this spawn; the counter still reloads.
                    if (cnt_expire && free_found) begin
                        do_spawn  = 1'b1;
                        spawn_idx = free_idx;
                    end
                end
            end
            default: state_d = ST_ARM;
        endcase

        // Kill beats a bottom-edge exit on the same slot, but loses to a spawn.
        if (kill_valid && !(do_spawn && spawn_idx == kill_slot)) begin
            slot_d[kill_slot].active = 1'b0;
            if (state_q == ST_MOVE && idx_q == kill_slot) begin
                avoided_d = 1'b0;
            end
        end

        if (do_spawn) begin
            slot_d[spawn_idx].active = 1'b1;
            slot_d[spawn_idx].x      = {1'b0, rand_val, 1'b0};
            slot_d[spawn_idx].y      = '0;
        end

        if (scene == SCENE_START && (scene_q == SCENE_PLAY || scene_q == SCENE_LOST)) begin
            state_d = ST_ARM;
        end
    end

    always_comb begin
        any_active_d = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            any_active_d = any_active_d | slot_d[i].active;
        end
        spawned_d = (scene == SCENE_START) && any_active_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARM;
            idx_q   <= '0;
            scene_q <= SCENE_START;
            avoided <= 1'b0;
            spawned <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scene_q <= scene;
            avoided <= avoided_d;
            spawned <= spawned_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            enemy_active[i]      = slot_q[i].active;
            enemy_x[10*i +: 10]  = slot_q[i].x;
            enemy_y[10*i +: 10]  = slot_q[i].y;
        end
    end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler: a scripted game from start screen through
// play, exits, kills, full-table skips, game over and restart.
module tb_enemy_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  scene;
    logic [4:0]  level;
    logic        tick;
    logic [7:0]  rand_val;
    logic        kill_valid;
    logic [1:0]  kill_slot;
    logic        spawned;
    logic        avoided;
    logic [3:0]  enemy_active;
    logic [39:0] enemy_x;
    logic [39:0] enemy_y;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int av_cnt;
    int av_first;
    int av_second;
    int av_total = 0;

    enemy_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .scene        (scene),
        .level        (level),
        .tick         (tick),
        .rand_val     (rand_val),
        .kill_valid   (kill_valid),
        .kill_slot    (kill_slot),
        .spawned      (spawned),
        .avoided      (avoided),
        .enemy_active (enemy_active),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .dbg_state    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] x_of(input int i);
        return enemy_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] y_of(input int i);
        return enemy_y[10*i +: 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: tick at cycle 0, optional kill strobe at cycle kill_at,
    // avoided sampled on every falling edge (slot k exits show up at cycle k+2).
    task automatic do_tick(input int kill_at, input logic [1:0] ks);
        av_cnt    = 0;
        av_first  = -1;
        av_second = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (avoided === 1'b1) begin
                if (av_cnt == 0) av_first = c;
                else if (av_cnt == 1) av_second = c;
                av_cnt++;
                av_total++;
            end
            tick       = (c == 0);
            kill_valid = (c == kill_at);
            kill_slot  = ks;
        end
        tick       = 1'b0;
        kill_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick(-1, 2'd0);
    endtask

    initial begin
        rst        = 1'b1;
        scene      = 2'd0;
        level      = 5'd1;
        tick       = 1'b0;
        rand_val   = 8'hA5;
        kill_valid = 1'b0;
        kill_slot  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_active", enemy_active, 4'b0000);
        check("rst_spawned", spawned, 1'b0);
        check("rst_avoided", avoided, 1'b0);
        check("rst_x", enemy_x[31:0], 32'd0);
        check("rst_y", enemy_y[31:0], 32'd0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        check("arm_to_wait", dbg_state, 2'd1);

        // Start screen: first tick places slot 0, further ticks add nothing.
        do_tick(-1, 2'd0);
        check("start_active", enemy_active, 4'b0001);
        check("start_x0", x_of(0), 10'h14A);
        check("start_y0", y_of(0), 10'd0);
        check("start_spawned", spawned, 1'b1);
        do_tick(-1, 2'd0);
        check("start_no_respawn", enemy_active, 4'b0001);
        check("start_spawned_hold", spawned, 1'b1);

        // Play, level 1: fresh counter spawns on the first pass, then every 60.
        scene    = 2'd1;
        rand_val = 8'h3C;
        @(negedge clk);
        check("play_spawned_low", spawned, 1'b0);
        do_tick(-1, 2'd0);
        check("t1_active", enemy_active, 4'b0011);
        check("t1_x1", x_of(1), 10'h078);
        check("t1_y1", y_of(1), 10'd0);
        check("t1_y0", y_of(0), 10'd1);
        ticks(59);
        check("t60_active", enemy_active, 4'b0011);
        check("t60_y0", y_of(0), 10'd60);
        check("t60_y1", y_of(1), 10'd59);
        level = 5'd20;
        do_tick(-1, 2'd0);
        check("t61_active", enemy_active, 4'b0111);
        check("t61_y0", y_of(0), 10'd66);
        ticks(11);
        check("t72_active", enemy_active, 4'b0111);
        do_tick(-1, 2'd0);
        check("t73_active", enemy_active, 4'b1111);
        check("t73_y0", y_of(0), 10'd138);
        check("t73_y3", y_of(3), 10'd0);

        // Table full through expiries at 85/97/109/121: all skipped.
        ticks(56);
        check("t129_active", enemy_active, 4'b1111);
        check("t129_y0", y_of(0), 10'd474);
        check("t129_y1", y_of(1), 10'd473);
        check("t129_no_avoid", av_total, 0);

        // Speed 7: slots 0 and 1 both cross the edge on one tick.
        level = 5'd24;
        do_tick(-1, 2'd0);
        check("dual_exit_count", av_cnt, 2);
        check("dual_exit_first", av_first, 2);
        check("dual_exit_second", av_second, 3);
        check("dual_exit_active", enemy_active, 4'b1100);
        ticks(2);
        check("t132_no_spawn", enemy_active, 4'b1100);
        do_tick(-1, 2'd0);
        check("t133_active", enemy_active, 4'b1101);
        check("t133_y0", y_of(0), 10'd0);
        check("t133_y2", y_of(2), 10'd436);

        // Level 4, speed 2: slot 2 walks to 478 then exits with a single pulse.
        level = 5'd4;
        ticks(21);
        check("t154_active", enemy_active, 4'b1111);
        check("t154_y2", y_of(2), 10'd478);
        check("t154_y3", y_of(3), 10'd406);
        do_tick(-1, 2'd0);
        check("exit_count", av_cnt, 1);
        check("exit_cycle", av_first, 4);
        check("exit_active", enemy_active, 4'b1011);

        // Kill slot 3 in the same cycle its move crosses the edge.
        level = 5'd28;
        ticks(8);
        check("t163_y3", y_of(3), 10'd472);
        do_tick(4, 2'd3);
        check("kill_exit_no_avoid", av_cnt, 0);
        check("kill_exit_active", enemy_active, 4'b0011);
        check("t164_y0", y_of(0), 10'd116);

        // Interval 51 from the reload at 145; kill on the spawn slot loses.
        ticks(31);
        check("t195_active", enemy_active, 4'b0011);
        do_tick(5, 2'd2);
        check("spawn_beats_kill", enemy_active, 4'b0111);
        check("t196_y2", y_of(2), 10'd0);
        check("t196_y0", y_of(0), 10'd372);
        check("t196_y1", y_of(1), 10'd348);

        kill_valid = 1'b1;
        kill_slot  = 2'd3;
        @(negedge clk);
        kill_valid = 1'b0;
        @(negedge clk);
        check("kill_inactive", enemy_active, 4'b0111);
        kill_valid = 1'b1;
        kill_slot  = 2'd1;
        @(negedge clk);
        kill_valid = 1'b0;
        @(negedge clk);
        check("kill_idle", enemy_active, 4'b0101);

        // Game over freezes the board; back to start clears it.
        scene = 2'd2;
        do_tick(-1, 2'd0);
        check("lost_frozen_y0", y_of(0), 10'd372);
        check("lost_active", enemy_active, 4'b0101);
        check("lost_no_avoid", av_cnt, 0);
        scene = 2'd0;
        repeat (3) @(negedge clk);
        check("restart_cleared", enemy_active, 4'b0000);
        check("restart_spawned", spawned, 1'b0);
        check("restart_state", dbg_state, 2'd1);
        rand_val = 8'h7F;
        do_tick(-1, 2'd0);
        check("restart_active", enemy_active, 4'b0001);
        check("restart_x0", x_of(0), 10'h0FE);
        check("restart_spawned_hi", spawned, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
